// File: rtl/cv32e41p_obi_mem_arbiter.sv
// Two-master OBI arbiter: instruction fetch and LSU share one memory port.
// A request is presented combinationally and held on the same master until
// granted. A small owner FIFO remembers who owns each outstanding
// transaction, so in-order responses are routed back to the right master.
module cv32e41p_obi_mem_arbiter #(
    parameter int MAX_OUTSTANDING = 2,  // legal range 1..4
    parameter int ARB_MODE        = 0   // 0: round-robin, 1: data has fixed priority
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,

    output logic        busy_o
);

    // Count needs to hold the value MAX_OUTSTANDING itself (up to 4).
    localparam logic [2:0] MAX_CNT  = 3'(MAX_OUTSTANDING);
    localparam logic [1:0] PTR_LAST = 2'(MAX_OUTSTANDING - 1);

    // Owner encoding: 0 = instruction master, 1 = data master.
    logic [2:0] cnt_q;
    logic [2:0] cnt_d;
    logic [1:0] wr_ptr_q;
    logic [1:0] rd_ptr_q;
    logic [3:0] owner_q;

    logic       rr_q;
    logic       lock_q;
    logic       lock_sel_q;

    logic       sel;
    logic       any_req;
    logic       cap_ok;
    logic       push;
    logic       pop;
    logic       head;

    assign any_req   = instr_req_i | data_req_i;
    assign cap_ok    = (cnt_q < MAX_CNT);
    assign mem_req_o = any_req & cap_ok;

    assign push = mem_req_o & mem_gnt_i;
    assign pop  = mem_rvalid_i & (cnt_q != 3'd0);
    assign head = owner_q[rd_ptr_q];

    // Pick the master to present: a pending lock wins, otherwise arbitrate on contention.
    always_comb begin
        sel = data_req_i;
        if (lock_q) begin
            sel = lock_sel_q;
        end else if (instr_req_i && data_req_i) begin
            sel = (ARB_MODE == 1) ? 1'b1 : rr_q;
        end
    end

    // Route the selected master's request fields; instruction fetches are full-word reads.
    always_comb begin
        mem_addr_o  = instr_addr_i;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'b1111;
        mem_wdata_o = 32'd0;
        if (sel) begin
            mem_addr_o  = data_addr_i;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_wdata_o = data_wdata_i;
        end
    end

    assign instr_gnt_o = mem_gnt_i & mem_req_o & ~sel;
    assign data_gnt_o  = mem_gnt_i & mem_req_o &  sel;

    // Responses carry no master id, so the FIFO head decides who gets them.
    assign instr_rvalid_o = pop & ~head;
    assign data_rvalid_o  = pop &  head;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign instr_err_o    = mem_err_i & instr_rvalid_o;
    assign data_err_o     = mem_err_i & data_rvalid_o;

    assign busy_o = (cnt_q != 3'd0) | mem_req_o;

    // Outstanding-count update; a push and pop together cancel out.
    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Owner FIFO: pop retires the old head, push appends the new owner at the tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 3'd0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            owner_q  <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
            if (push) begin
                owner_q[wr_ptr_q] <= sel;
                wr_ptr_q          <= (wr_ptr_q == PTR_LAST) ? 2'd0 : wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? 2'd0 : rd_ptr_q + 2'd1;
            end
        end
    end

    // Hold an ungranted selection stable, and hand tie priority to the master just passed over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= 1'b0;
            lock_q     <= 1'b0;
            lock_sel_q <= 1'b0;
        end else begin
            lock_q <= mem_req_o & ~mem_gnt_i;
            if (mem_req_o && !mem_gnt_i) begin
                lock_sel_q <= sel;
            end
            if (push) begin
                rr_q <= ~sel;
            end
        end
    end

endmodule

// File: tb/tb_cv32e41p_obi_mem_arbiter.sv
// Bench for the two-master OBI arbiter. Two instances share the stimulus:
// index 0 is round-robin, index 1 is data-fixed-priority, both with two
// outstanding transactions allowed.
module tb_cv32e41p_obi_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        instr_req, data_req, data_we;
    logic [31:0] instr_addr, data_addr, data_wdata;
    logic [3:0]  data_be;
    logic        mem_gnt, mem_rvalid, mem_err;
    logic [31:0] mem_rdata;

    logic [1:0]  instr_gnt_w, instr_rvalid_w, instr_err_w;
    logic [1:0]  data_gnt_w, data_rvalid_w, data_err_w;
    logic [1:0]  mem_req_w, mem_we_w, busy_w;
    logic [31:0] instr_rdata_w [2];
    logic [31:0] data_rdata_w [2];
    logic [31:0] mem_addr_w [2];
    logic [31:0] mem_wdata_w [2];
    logic [3:0]  mem_be_w [2];

    int tests_run = 0;
    int fails     = 0;

    cv32e41p_obi_mem_arbiter #(.MAX_OUTSTANDING(2), .ARB_MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr),
        .instr_gnt_o(instr_gnt_w[0]), .instr_rvalid_o(instr_rvalid_w[0]),
        .instr_rdata_o(instr_rdata_w[0]), .instr_err_o(instr_err_w[0]),
        .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
        .data_addr_i(data_addr), .data_wdata_i(data_wdata),
        .data_gnt_o(data_gnt_w[0]), .data_rvalid_o(data_rvalid_w[0]),
        .data_rdata_o(data_rdata_w[0]), .data_err_o(data_err_w[0]),
        .mem_req_o(mem_req_w[0]), .mem_we_o(mem_we_w[0]), .mem_be_o(mem_be_w[0]),
        .mem_addr_o(mem_addr_w[0]), .mem_wdata_o(mem_wdata_w[0]),
        .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
        .busy_o(busy_w[0])
    );

    cv32e41p_obi_mem_arbiter #(.MAX_OUTSTANDING(2), .ARB_MODE(1)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr),
        .instr_gnt_o(instr_gnt_w[1]), .instr_rvalid_o(instr_rvalid_w[1]),
        .instr_rdata_o(instr_rdata_w[1]), .instr_err_o(instr_err_w[1]),
        .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
        .data_addr_i(data_addr), .data_wdata_i(data_wdata),
        .data_gnt_o(data_gnt_w[1]), .data_rvalid_o(data_rvalid_w[1]),
        .data_rdata_o(data_rdata_w[1]), .data_err_o(data_err_w[1]),
        .mem_req_o(mem_req_w[1]), .mem_we_o(mem_we_w[1]), .mem_be_o(mem_be_w[1]),
        .mem_addr_o(mem_addr_w[1]), .mem_wdata_o(mem_wdata_w[1]),
        .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
        .busy_o(busy_w[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        instr_req  = 1'b0; instr_addr = 32'd0;
        data_req   = 1'b0; data_we    = 1'b0; data_be = 4'd0;
        data_addr  = 32'd0; data_wdata = 32'd0;
        mem_gnt    = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = 32'd0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        clear_inputs();
        rst_n = 1'b0;
        #2;
        for (int k = 0; k < 2; k++) begin
            obs = {mem_req_w[k], instr_gnt_w[k], data_gnt_w[k], instr_rvalid_w[k],
                   data_rvalid_w[k], instr_err_w[k], data_err_w[k], busy_w[k]};
            tests_run++;
            if (obs !== 8'd0) begin
                fails++;
                $display("FAIL reset_outputs inst%0d got %b want 00000000", k, obs);
            end
        end
        mem_rvalid = 1'b1; mem_err = 1'b1;
        #1;
        obs = {4'd0, instr_rvalid_w[0], data_rvalid_w[0], instr_err_w[0], data_err_w[0]};
        tests_run++;
        if (obs !== 8'd0) begin
            fails++;
            $display("FAIL reset_spurious_rvalid got %b want 00000000", obs);
        end
        clear_inputs();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_instr_stream();
        logic [5:0]  obs, exp;
        logic [68:0] fobs, fexp;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            instr_req  = (c < 3);
            instr_addr = 32'hA0 + 32'(4 * c);
            mem_gnt    = 1'b1;
            mem_rvalid = (c >= 1 && c <= 3);
            mem_rdata  = 32'hD000_0000 + 32'(c);
            #1;
            exp = {c < 3, c < 3, 1'b0, c >= 1 && c <= 3, 1'b0, c < 4};
            obs = {mem_req_w[0], instr_gnt_w[0], data_gnt_w[0], instr_rvalid_w[0],
                   data_rvalid_w[0], busy_w[0]};
            tests_run++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL instr_stream_ctl c%0d got %b want %b", c, obs, exp);
            end
            if (c < 3) begin
                fexp = {32'hA0 + 32'(4 * c), 1'b0, 4'hF, 32'd0};
                fobs = {mem_addr_w[0], mem_we_w[0], mem_be_w[0], mem_wdata_w[0]};
                tests_run++;
                if (fobs !== fexp) begin
                    fails++;
                    $display("FAIL instr_stream_fields c%0d got %h want %h", c, fobs, fexp);
                end
            end
            if (c >= 1 && c <= 3) begin
                tests_run++;
                if (instr_rdata_w[0] !== 32'hD000_0000 + 32'(c)) begin
                    fails++;
                    $display("FAIL instr_stream_rdata c%0d got %h want %h", c,
                             instr_rdata_w[0], 32'hD000_0000 + 32'(c));
                end
            end
            obs = {data_gnt_w[0], data_rvalid_w[0], data_err_w[0], instr_err_w[0], 2'b00};
            tests_run++;
            if (obs !== 6'd0) begin
                fails++;
                $display("FAIL instr_stream_data_quiet c%0d got %b want 000000", c, obs);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_round_robin();
        logic [4:0] obs, exp;
        bit         win;
        bit         prev;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            instr_req  = (c < 4);
            data_req   = (c < 4);
            instr_addr = 32'h100 + 32'(4 * c);
            data_addr  = 32'h200 + 32'(4 * c);
            data_we    = 1'b1; data_be = 4'h3; data_wdata = 32'h5A5A_0000 + 32'(c);
            mem_gnt    = 1'b1;
            mem_rvalid = (c >= 1);
            win  = (c % 2) == 1;
            prev = ((c - 1) % 2) == 1;
            #1;
            exp = {c < 4, c < 4 && !win, c < 4 && win, c >= 1 && !prev, c >= 1 && prev};
            obs = {mem_req_w[0], instr_gnt_w[0], data_gnt_w[0], instr_rvalid_w[0], data_rvalid_w[0]};
            tests_run++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL round_robin c%0d got %b want %b", c, obs, exp);
            end
            if (c < 4) begin
                tests_run++;
                if (mem_addr_w[0] !== (win ? 32'h200 + 32'(4 * c) : 32'h100 + 32'(4 * c))) begin
                    fails++;
                    $display("FAIL round_robin_addr c%0d got %h want %h", c, mem_addr_w[0],
                             win ? 32'h200 + 32'(4 * c) : 32'h100 + 32'(4 * c));
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_fixed_lock();
        logic [2:0]  obs, exp;
        logic [68:0] fobs, fexp;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            instr_req  = (c <= 3);
            instr_addr = 32'h300;
            data_req   = (c >= 1 && c <= 4);
            data_addr  = 32'h400; data_we = 1'b1; data_be = 4'h3; data_wdata = 32'hCAFE_0001;
            mem_gnt    = (c == 3 || c == 4);
            mem_rvalid = (c >= 5);
            #1;
            exp = {c <= 4, c == 3, c == 4};
            obs = {mem_req_w[1], instr_gnt_w[1], data_gnt_w[1]};
            tests_run++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL fixed_lock_gnt c%0d got %b want %b", c, obs, exp);
            end
            if (c <= 4) begin
                fexp = (c <= 3) ? {32'h300, 1'b0, 4'hF, 32'd0} : {32'h400, 1'b1, 4'h3, 32'hCAFE_0001};
                fobs = {mem_addr_w[1], mem_we_w[1], mem_be_w[1], mem_wdata_w[1]};
                tests_run++;
                if (fobs !== fexp) begin
                    fails++;
                    $display("FAIL fixed_lock_fields c%0d got %h want %h", c, fobs, fexp);
                end
            end
            if (c >= 5) begin
                obs = {instr_rvalid_w[1], data_rvalid_w[1], 1'b0};
                exp = {c == 5, c == 6, 1'b0};
                tests_run++;
                if (obs !== exp) begin
                    fails++;
                    $display("FAIL fixed_lock_resp c%0d got %b want %b", c, obs, exp);
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_capacity();
        logic [3:0] obs, exp;
        logic [3:0] req_e, gnt_e, rv_e, busy_e;
        int         gnts;
        do_reset();
        req_e  = 4'b0; gnt_e = 4'b0; rv_e = 4'b0; busy_e = 4'b0;
        gnts = 0;
        for (int c = 0; c < 10; c++) begin
            instr_req  = (c <= 6);
            instr_addr = 32'h800 + 32'(4 * gnts);
            mem_gnt    = 1'b1;
            mem_rvalid = (c == 5 || c == 7 || c == 8);
            #1;
            exp = {c <= 1 || c == 6, c <= 1 || c == 6, c == 5 || c == 7 || c == 8, c <= 8};
            obs = {mem_req_w[0], instr_gnt_w[0], instr_rvalid_w[0], busy_w[0]};
            tests_run++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL capacity c%0d got %b want %b", c, obs, exp);
            end
            if (exp[2]) gnts++;
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_push_pop_spurious();
        logic [5:0] obs, exp;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            data_req   = (c == 0); data_addr = 32'h600; data_we = 1'b0; data_be = 4'hF;
            instr_req  = (c == 1); instr_addr = 32'h700;
            mem_gnt    = (c <= 1);
            mem_rvalid = (c >= 1 && c <= 3);
            mem_err    = (c == 3);
            #1;
            exp = {c == 1, c == 0, c == 2, c == 1, 1'b0, c <= 2};
            obs = {instr_gnt_w[0], data_gnt_w[0], instr_rvalid_w[0], data_rvalid_w[0],
                   instr_err_w[0] | data_err_w[0], busy_w[0]};
            tests_run++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL push_pop_spurious c%0d got %b want %b", c, obs, exp);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        logic [3:0] obs, exp;
        do_reset();
        instr_req = 1'b1; instr_addr = 32'h900; mem_gnt = 1'b1;
        tick();
        instr_addr = 32'h904;
        tick();
        instr_req = 1'b0; mem_gnt = 1'b0;
        #1;
        tests_run++;
        if ({mem_req_w[0], busy_w[0]} !== 2'b01) begin
            fails++;
            $display("FAIL reset_mid_before got %b want 01", {mem_req_w[0], busy_w[0]});
        end
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (busy_w[0] !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_busy got %b want 0", busy_w[0]);
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            mem_rvalid = (c != 1);
            instr_req  = (c == 1); instr_addr = 32'hA00; mem_gnt = (c == 1);
            #1;
            exp = {c == 1, c == 1, c == 2, c >= 1};
            obs = {mem_req_w[0], instr_gnt_w[0], instr_rvalid_w[0] | data_rvalid_w[0], busy_w[0]};
            tests_run++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL reset_mid_after c%0d got %b want %b", c, obs, exp);
            end
            tick();
        end
        clear_inputs();
    endtask

    // Transaction-level model: a queue of owners, a tie-break preference and a held winner.
    task automatic test_random(input int k, input int n);
        bit          pi, pd, dwe;
        logic [31:0] ia, da, dw;
        logic [3:0]  dbe;
        bit          own [8];
        int          hd, sz;
        bit          tie_d, held, held_who, mreq, win, rv_ok, hown;
        logic [7:0]  e_v, o_v;
        logic [68:0] e_f, o_f;
        logic [31:0] o_rd;
        pi = 0; pd = 0; dwe = 0; ia = 0; da = 0; dw = 0; dbe = 0;
        hd = 0; sz = 0; tie_d = 0; held = 0; held_who = 0;
        for (int i = 0; i < 8; i++) own[i] = 0;
        do_reset();
        for (int c = 0; c < n; c++) begin
            if (!pi && $urandom_range(0, 2) != 0) begin
                pi = 1; ia = $urandom() & 32'hFFFF_FFFC;
            end
            if (!pd && $urandom_range(0, 2) != 0) begin
                pd = 1; da = $urandom() & 32'hFFFF_FFFC; dwe = $urandom_range(0, 1) == 1;
                dbe = 4'($urandom_range(1, 15)); dw = $urandom();
            end
            instr_req = pi; instr_addr = ia;
            data_req = pd; data_addr = da; data_we = dwe; data_be = dbe; data_wdata = dw;
            mem_gnt    = $urandom_range(0, 3) != 0;
            mem_rvalid = $urandom_range(0, 1) == 1;
            mem_rdata  = $urandom();
            mem_err    = $urandom_range(0, 5) == 0;
            #1;
            mreq = (pi || pd) && sz < 2;
            if (held) win = held_who;
            else if (pi && pd) win = (k == 1) ? 1'b1 : tie_d;
            else win = pd;
            rv_ok = mem_rvalid && sz > 0;
            hown  = own[hd];
            e_v = {mreq, mem_gnt && mreq && !win, mem_gnt && mreq && win,
                   rv_ok && !hown, rv_ok && hown,
                   rv_ok && !hown && mem_err, rv_ok && hown && mem_err, sz != 0 || mreq};
            o_v = {mem_req_w[k], instr_gnt_w[k], data_gnt_w[k], instr_rvalid_w[k],
                   data_rvalid_w[k], instr_err_w[k], data_err_w[k], busy_w[k]};
            tests_run++;
            if (o_v !== e_v) begin
                fails++;
                $display("FAIL random_ctl inst%0d c%0d got %b want %b", k, c, o_v, e_v);
            end
            if (mreq) begin
                e_f = win ? {da, dwe, dbe, dw} : {ia, 1'b0, 4'hF, 32'd0};
                o_f = {mem_addr_w[k], mem_we_w[k], mem_be_w[k], mem_wdata_w[k]};
                tests_run++;
                if (o_f !== e_f) begin
                    fails++;
                    $display("FAIL random_fields inst%0d c%0d got %h want %h", k, c, o_f, e_f);
                end
            end
            if (rv_ok) begin
                o_rd = hown ? data_rdata_w[k] : instr_rdata_w[k];
                tests_run++;
                if (o_rd !== mem_rdata) begin
                    fails++;
                    $display("FAIL random_rdata inst%0d c%0d got %h want %h", k, c, o_rd, mem_rdata);
                end
            end
            if (rv_ok) begin
                hd = (hd + 1) % 8;
                sz--;
            end
            if (mreq && mem_gnt) begin
                own[(hd + sz) % 8] = win;
                sz++;
                tie_d = !win;
                if (win) pd = 0;
                else pi = 0;
            end
            held     = mreq && !mem_gnt;
            held_who = win;
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_instr_stream();
        test_round_robin();
        test_fixed_lock();
        test_capacity();
        test_push_pop_spurious();
        test_reset_mid();
        test_random(0, 600);
        test_random(1, 600);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/cv32e41p_obi_mem_arbiter.md
# cv32e41p_obi_mem_arbiter

Two-master OBI arbiter that shares one memory port between the instruction-fetch requester (IF-stage prefetch buffer) and the LSU data requester, for configurations with a single unified instruction/data memory. It sits between the core's `instr_*` and `data_*` OBI ports and the shared memory. It selects which master's request is presented to memory and holds that selection OBI-stable until it is granted. It tracks the owner of every outstanding transaction so that each in-order response is routed back to the correct master.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 2: maximum granted-but-unanswered transactions. Legal range is 1..4.
- `ARB_MODE`, default 0: arbitration policy. 0 = round-robin; 1 = fixed priority, data master wins.

Ports:
- Clock and reset: single clock; reset is asynchronous and active-low.
  - `clk` in 1: clock.
  - `rst_n` in 1: reset.
- Instruction master:
  - `instr_req_i` in 1
  - `instr_addr_i` in 32
  - `instr_gnt_o` out 1
  - `instr_rvalid_o` out 1
  - `instr_rdata_o` out 32
  - `instr_err_o` out 1
- Data master:
  - `data_req_i` in 1
  - `data_we_i` in 1
  - `data_be_i` in 4
  - `data_addr_i` in 32
  - `data_wdata_i` in 32
  - `data_gnt_o` out 1
  - `data_rvalid_o` out 1
  - `data_rdata_o` out 32
  - `data_err_o` out 1
- Memory slave:
  - `mem_req_o` out 1
  - `mem_we_o` out 1
  - `mem_be_o` out 4
  - `mem_addr_o` out 32
  - `mem_wdata_o` out 32
  - `mem_gnt_i` in 1
  - `mem_rvalid_i` in 1
  - `mem_rdata_i` in 32
  - `mem_err_i` in 1
- Status:
  - `busy_o` out 1: outstanding count ≠ 0 OR `mem_req_o`.

## Operation
- **Capacity gate.**
  - `mem_req_o` = (`instr_req_i` | `data_req_i`) & (count < `MAX_OUTSTANDING`).
  - count increments only on a grant, which also ends the request. Count therefore never rises under a pending request, so `mem_req_o` never drops before `mem_gnt_i`.
- **Selection.**
  - When no lock is held and both masters request:
    - `ARB_MODE`=1: data wins.
    - `ARB_MODE`=0: the master flagged by the round-robin pointer `rr_q` wins. `rr_q`=0 means instr has priority.
  - A single requester always wins.
- **Lock.**
  - If `mem_req_o`=1 and `mem_gnt_i`=0, the current winner is latched into `lock_q`/`lock_sel_q`.
  - While the lock is held, the selection stays on that master regardless of the other requester.
  - The lock clears on `mem_gnt_i`.
  - Masters keep their own request stable per OBI, so `mem_addr_o`, `mem_we_o`, `mem_be_o` and `mem_wdata_o` remain stable.
- **Muxing.**
  - Selected instr: `mem_we_o`=0, `mem_be_o`=4'b1111, `mem_wdata_o`=0, `mem_addr_o`=`instr_addr_i`.
  - Selected data: pass `data_*` through.
- **Grant.**
  - `instr_gnt_o` = `mem_gnt_i` & `mem_req_o` & (sel==instr).
  - `data_gnt_o` follows the same rule for data.
  - The loser always sees gnt=0.
- **Owner FIFO.**
  - Depth `MAX_OUTSTANDING`, 1-bit entries (0 = instr, 1 = data), plus read/write pointers and a count.
  - Push the selected owner on `mem_req_o & mem_gnt_i`.
  - Pop on `mem_rvalid_i` when count ≠ 0.
  - Push and pop in the same cycle leave count unchanged.
- **Response routing.**
  - `instr_rvalid_o` = `mem_rvalid_i` & count≠0 & head==0.
  - `data_rvalid_o` = `mem_rvalid_i` & count≠0 & head==1.
  - `*_rdata_o` = `mem_rdata_i` to both masters; the value is meaningful only with the master's rvalid.
  - `*_err_o` = `mem_err_i` gated by that master's rvalid.
- **Round-robin update.**
  - On each grant, `rr_q` points to the master that was not granted.
  - With `ARB_MODE`=1, `rr_q` is unused.
- **Spurious response.** `mem_rvalid_i` with count==0 is ignored: no pop, both rvalid outputs stay 0.

## Timing
- Reset values:
  - State: count=0, FIFO pointers=0, `rr_q`=0, `lock_q`=0.
  - Outputs: all gnt/rvalid/err outputs 0, `mem_req_o`=0, `busy_o`=0.
  - Outputs driven combinationally from inputs follow those inputs after reset release.
- Request to memory: zero cycles. `mem_req_o`, the muxed fields and the returned gnt are combinational.
- Response routing: zero cycles, combinational from `mem_rvalid_i` and the FIFO head.
- Throughput: one grant per cycle, as long as count < `MAX_OUTSTANDING`.
- FIFO full:
  - `mem_req_o` stays 0 until a pop has registered.
  - No bypass: a pop and a new request in the same cycle still see count=MAX, so the request waits one cycle.
- Reset mid-operation clears all tracking immediately. Responses still in flight after reset release count as spurious and are dropped.
- Same-cycle grant and response: the response pops the old head, then the new owner is pushed at the tail.

## Test plan
- **Single-master instr stream.** Instr requests A0, A4, A8 with gnt tied to 1 and rvalid one cycle later:
  - three instr grants in consecutive cycles;
  - `instr_rvalid_o` on each response;
  - `mem_be_o`=4'hF, `mem_we_o`=0;
  - `data_*` outputs stay 0.
- **Round-robin contention** (`ARB_MODE`=0). Both masters request continuously, gnt=1, `MAX_OUTSTANDING`=2, responses one cycle after grant:
  - grant order is instr, data, instr, data;
  - responses are routed in that order.
- **Fixed priority and lock** (`ARB_MODE`=1). Instr requests alone; gnt is held 0 for 3 cycles; data asserts on the 2nd cycle:
  - `mem_addr_o` stays on the instr address until the instr gnt;
  - data is granted the following cycle.
- **Capacity.** `MAX_OUTSTANDING`=2, gnt=1, rvalid withheld for 5 cycles:
  - exactly 2 grants, then `mem_req_o`=0 with `busy_o`=1;
  - the first rvalid pops one entry;
  - the next grant occurs the cycle after the pop.
- **Same-cycle push/pop and spurious response.**
  - Count=1 (head=data), then a new instr grant coincides with rvalid: `data_rvalid_o` pulses, count stays 1, and the next response goes to instr.
  - rvalid with count=0: no rvalid output pulses.
- **Reset mid-operation.** Assert `rst_n`=0 with 2 transactions outstanding:
  - count=0 and `busy_o`=0 immediately;
  - after release, a late `mem_rvalid_i` is ignored;
  - a fresh instr request is granted normally.
